// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for the accelerator control register block:
// register offsets, STATUS bit positions, AXI response codes and FSM states.
package accel_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_STATUS  = 5'h04;
    localparam logic [4:0] OFF_CFG_K   = 5'h08;
    localparam logic [4:0] OFF_IRQ_EN  = 5'h0C;
    localparam logic [4:0] OFF_JOB_CNT = 5'h10;
    localparam logic [4:0] OFF_ID      = 5'h14;

    localparam logic [2:0] IDX_CTRL    = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS  = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_CFG_K   = OFF_CFG_K[4:2];
    localparam logic [2:0] IDX_IRQ_EN  = OFF_IRQ_EN[4:2];
    localparam logic [2:0] IDX_JOB_CNT = OFF_JOB_CNT[4:2];
    localparam logic [2:0] IDX_ID      = OFF_ID[4:2];

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;
    typedef enum logic { JOB_IDLE, JOB_RUN } job_state_t;

endpackage

// File: rtl/accel_ctrl_regs_axil_reg_if.sv
// AXI4-Lite slave handshake engine: turns the five channels into
// single-cycle register write/read strobes for the decode logic.
module axil_reg_if
    import accel_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    input  logic              wr_err_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_err_i
);

    w_state_t          w_state_q;
    r_state_t          r_state_q;
    logic              awready_q, wready_q, arready_q;
    logic              aw_got_q, w_got_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;

    logic aw_hs, w_hs, have_aw, have_w, commit, ar_hs;

    // AW and W may arrive in either order; commit once both are held
    assign aw_hs   = awvalid_i & awready_q;
    assign w_hs    = wvalid_i & wready_q;
    assign have_aw = aw_got_q | aw_hs;
    assign have_w  = w_got_q | w_hs;
    assign commit  = (w_state_q == W_IDLE) & have_aw & have_w;
    assign ar_hs   = arvalid_i & arready_q;

    assign wr_en_o   = commit;
    assign wr_addr_o = aw_got_q ? aw_addr_q : awaddr_i;
    assign wr_data_o = w_got_q ? w_data_q : wdata_i;
    assign wr_strb_o = w_got_q ? w_strb_q : wstrb_i;
    assign rd_en_o   = ar_hs;
    assign rd_addr_o = araddr_i;

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_got_q  <= 1'b1;
                            aw_addr_q <= awaddr_i;
                        end
                        if (w_hs) begin
                            w_got_q  <= 1'b1;
                            w_data_q <= wdata_i;
                            w_strb_q <= wstrb_i;
                        end
                        awready_q <= ~have_aw;
                        wready_q  <= ~have_w;
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data_i;
                        rresp_q   <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/accel_ctrl_regs.sv
// Control/status registers and job sequencer in front of compute_wrapper:
// launches jobs, tracks BUSY, and latches completion into DONE/IRQ/JOB_CNT.
module accel_ctrl_regs
    import accel_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 32,
    parameter int          K_MAX    = 64,
    parameter int          K_RESET  = 4,
    parameter logic [31:0] ID_VALUE = 32'hACC0_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [15:0]       cfg_k,
    output logic              start,
    input  logic              done_pulse,
    output logic              done,
    output logic              irq
);

    localparam logic [15:0] KMAX16 = 16'(K_MAX);
    localparam logic [15:0] KRST16 = 16'(K_RESET);

    logic              wr_en, wr_err, rd_en, rd_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic [2:0]        wr_idx, rd_idx;

    axil_reg_if #(.ADDR_W(ADDR_W)) u_if (
        .clk       (clk),
        .rst       (rst),
        .awaddr_i  (s_axil_awaddr),
        .awvalid_i (s_axil_awvalid),
        .awready_o (s_axil_awready),
        .wdata_i   (s_axil_wdata),
        .wstrb_i   (s_axil_wstrb),
        .wvalid_i  (s_axil_wvalid),
        .wready_o  (s_axil_wready),
        .bresp_o   (s_axil_bresp),
        .bvalid_o  (s_axil_bvalid),
        .bready_i  (s_axil_bready),
        .araddr_i  (s_axil_araddr),
        .arvalid_i (s_axil_arvalid),
        .arready_o (s_axil_arready),
        .rdata_o   (s_axil_rdata),
        .rresp_o   (s_axil_rresp),
        .rvalid_o  (s_axil_rvalid),
        .rready_i  (s_axil_rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_err_i  (wr_err),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .rd_err_i  (rd_err)
    );

    job_state_t  job_q;
    logic [15:0] cfg_k_q, cfg_k_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, err_q, start_q;
    logic [31:0] cnt_q;

    logic busy, start_req, start_ok, done_clr, err_clr, done_set;

    assign wr_idx = wr_addr[4:2];
    assign rd_idx = rd_addr[4:2];
    assign busy   = (job_q == JOB_RUN);
    assign wr_err = wr_en & (wr_idx > IDX_ID);
    assign rd_err = rd_idx > IDX_ID;

    assign start_req = wr_en & (wr_idx == IDX_CTRL) & wr_strb[0] & wr_data[0];
    assign start_ok  = start_req & ~busy & (cfg_k_q != 16'd0) & (cfg_k_q <= KMAX16);
    assign done_clr  = wr_en & (wr_idx == IDX_STATUS) & wr_strb[0] & wr_data[STAT_DONE];
    assign err_clr   = wr_en & (wr_idx == IDX_STATUS) & wr_strb[0] & wr_data[STAT_ERR];
    assign done_set  = busy & done_pulse;

    always_comb begin
        cfg_k_d  = cfg_k_q;
        irq_en_d = irq_en_q;
        // cfg_k is frozen while a job runs so the wrapper sees a stable K
        if (wr_en && wr_idx == IDX_CFG_K && !busy) begin
            if (wr_strb[0]) cfg_k_d[7:0]  = wr_data[7:0];
            if (wr_strb[1]) cfg_k_d[15:8] = wr_data[15:8];
        end
        if (wr_en && wr_idx == IDX_IRQ_EN && wr_strb[0]) begin
            irq_en_d = wr_data[0];
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (rd_idx)
            IDX_STATUS: begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done_q;
                rd_data[STAT_ERR]  = err_q;
            end
            IDX_CFG_K:   rd_data[15:0] = cfg_k_q;
            IDX_IRQ_EN:  rd_data[0]    = irq_en_q;
            IDX_JOB_CNT: rd_data       = cnt_q;
            IDX_ID:      rd_data       = ID_VALUE;
            default:     rd_data       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_q    <= JOB_IDLE;
            cfg_k_q  <= KRST16;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cfg_k_q  <= cfg_k_d;
            irq_en_q <= irq_en_d;
            start_q  <= start_ok;
            unique case (job_q)
                JOB_IDLE: if (start_ok) job_q <= JOB_RUN;
                JOB_RUN: begin
                    if (done_pulse) begin
                        job_q <= JOB_IDLE;
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: job_q <= JOB_IDLE;
            endcase
            // completion set outranks a coincident W1C
            if (done_set)      done_q <= 1'b1;
            else if (start_ok) done_q <= 1'b0;
            else if (done_clr) done_q <= 1'b0;
            if (start_req && !start_ok) err_q <= 1'b1;
            else if (err_clr)           err_q <= 1'b0;
        end
    end

    assign cfg_k = cfg_k_q;
    assign start = start_q;
    assign done  = done_q;
    assign irq   = done_q & irq_en_q;

    logic unused_bits;
    assign unused_bits = ^{rd_en, wr_data[31:16], wr_strb[3:2],
                           wr_addr, rd_addr};

endmodule

// File: tb/tb_accel_ctrl_regs.sv
// Directed bench for accel_ctrl_regs: AXI responses are checked by a
// queue-based monitor, sideband outputs by inline checks.
module tb_accel_ctrl_regs;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [7:0]  s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic [15:0] cfg_k;
    logic        start;
    logic        done_pulse = 1'b0;
    logic        done;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int s0;

    rd_exp_t     rq[$];
    logic [1:0]  wq[$];
    logic        r_hold = 1'b0;
    logic [31:0] r_held;
    logic [1:0]  r_held_resp;

    accel_ctrl_regs dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .cfg_k          (cfg_k),
        .start          (start),
        .done_pulse     (done_pulse),
        .done           (done),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start === 1'b1) start_cnt++;
    end

    // Read/write response monitor
    always @(negedge clk) begin
        rd_exp_t e;
        if (!rst && s_axil_rvalid) begin
            if (r_hold) begin
                chk("rdata_stable", s_axil_rdata, r_held);
                chk("rresp_stable", {30'd0, s_axil_rresp}, {30'd0, r_held_resp});
            end
            r_hold = 1'b1;
            r_held = s_axil_rdata;
            r_held_resp = s_axil_rresp;
            if (s_axil_rready) begin
                r_hold = 1'b0;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk($sformatf("rd%02h_data", e.addr), s_axil_rdata, e.data);
                    chk($sformatf("rd%02h_resp", e.addr),
                        {30'd0, s_axil_rresp}, {30'd0, e.resp});
                end
            end
        end
        if (!rst && s_axil_bvalid && s_axil_bready) begin
            if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else chk("bresp", {30'd0, s_axil_bresp}, {30'd0, wq.pop_front()});
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er,
                             input int lead, input int stall, input bit dp);
        bit awd, wd, bd, fa, fw;
        int n, seen;
        wq.push_back(er);
        s_axil_awaddr  = a;
        s_axil_wdata   = d;
        s_axil_wstrb   = s;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = (lead == 0);
        if (dp && lead == 0) done_pulse = 1'b1;
        s_axil_bready = (stall == 0);
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 50) begin
            @(negedge clk);
            fa = s_axil_awvalid && s_axil_awready;
            fw = s_axil_wvalid && s_axil_wready;
            @(posedge clk); #1;
            done_pulse = 1'b0;
            if (fa) begin awd = 1; s_axil_awvalid = 1'b0; end
            if (fw) begin wd = 1; s_axil_wvalid = 1'b0; end
            n++;
            if (lead > 0 && n == lead) begin
                s_axil_wvalid = 1'b1;
                if (dp) done_pulse = 1'b1;
            end
        end
        if (!(awd && wd)) chk("aw_w_timeout", 32'd1, 32'd0);
        bd = 0; n = 0; seen = 0;
        while (!bd && n < 50) begin
            @(negedge clk);
            if (s_axil_bvalid && s_axil_bready) bd = 1;
            @(posedge clk); #1;
            if (s_axil_bvalid) seen++;
            s_axil_bready = (seen >= stall);
            n++;
        end
        s_axil_bready = 1'b0;
        if (!bd) chk("b_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        axi_write(a, d, 4'hF, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] d,
                            input logic [1:0] er, input int stall);
        bit ad, rd, fa;
        int n, seen;
        rq.push_back('{addr: a, data: d, resp: er});
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        s_axil_rready  = (stall == 0);
        ad = 0; n = 0;
        while (!ad && n < 50) begin
            @(negedge clk);
            fa = s_axil_arvalid && s_axil_arready;
            @(posedge clk); #1;
            if (fa) begin ad = 1; s_axil_arvalid = 1'b0; end
            n++;
        end
        if (!ad) chk("ar_timeout", 32'd1, 32'd0);
        rd = 0; n = 0; seen = 0;
        while (!rd && n < 50) begin
            @(negedge clk);
            if (s_axil_rvalid && s_axil_rready) rd = 1;
            @(posedge clk); #1;
            if (s_axil_rvalid) seen++;
            s_axil_rready = (seen >= stall);
            n++;
        end
        s_axil_rready = 1'b0;
        if (!rd) chk("r_timeout", 32'd1, 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] d);
        axi_read(a, d, 2'b00, 0);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done_pulse = 1'b1;
        @(posedge clk); #1;
        done_pulse = 1'b0;
    endtask

    task automatic launch(input string name, input int exp_pulses);
        s0 = start_cnt;
        wr(8'h00, 32'h1);
        repeat (2) @(negedge clk);
        chk(name, start_cnt - s0, exp_pulses);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd0);
        chk("rst_valid", {30'd0, s_axil_bvalid, s_axil_rvalid}, 32'd0);
        chk("rst_outs", {29'd0, start, done, irq}, 32'd0);
        chk("rst_cfg_k", {16'd0, cfg_k}, 32'd4);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        rd(8'h08, 32'h4);
        rd(8'h14, 32'hACC0_0001);
        rd(8'h04, 32'h0);
        rd(8'h10, 32'h0);

        // basic job
        wr(8'h08, 32'h4);
        launch("start_one_cycle", 1);
        rd(8'h04, 32'h1);
        repeat (20) @(posedge clk); #1;
        pulse_done();
        @(negedge clk);
        chk("done_set", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        rd(8'h04, 32'h2);
        rd(8'h10, 32'h1);
        repeat (10) @(negedge clk);
        chk("done_sticky", {31'd0, done}, 32'd1);
        @(posedge clk); #1;

        // interrupt path
        wr(8'h04, 32'h2);
        wr(8'h0C, 32'h1);
        @(negedge clk);
        chk("irq_idle", {30'd0, done, irq}, 32'd0);
        @(posedge clk); #1;
        launch("start_irq_job", 1);
        pulse_done();
        @(negedge clk);
        chk("irq_rise", {30'd0, done, irq}, 32'h3);
        @(posedge clk); #1;
        wr(8'h04, 32'h2);
        @(negedge clk);
        chk("irq_clear", {30'd0, done, irq}, 32'h0);
        @(posedge clk); #1;

        // errors while busy, CFG_K lock, set-vs-clear race
        launch("start_job3", 1);
        launch("start_busy_rej", 0);
        rd(8'h04, 32'h5);
        wr(8'h04, 32'h4);
        rd(8'h04, 32'h1);
        wr(8'h08, 32'h8);
        rd(8'h08, 32'h4);
        axi_write(8'h04, 32'h2, 4'hF, 2'b00, 0, 0, 1'b1);
        @(negedge clk);
        chk("done_set_wins", {30'd0, done, irq}, 32'h3);
        @(posedge clk); #1;
        rd(8'h04, 32'h2);
        rd(8'h10, 32'h3);

        // K range boundaries
        wr(8'h08, 32'h0);
        launch("start_k0_rej", 0);
        rd(8'h04, 32'h6);
        wr(8'h04, 32'h4);
        rd(8'h04, 32'h2);
        wr(8'h08, 32'd65);
        launch("start_k65_rej", 0);
        rd(8'h04, 32'h6);
        wr(8'h04, 32'h6);
        rd(8'h04, 32'h0);
        wr(8'h08, 32'd64);
        launch("start_k64", 1);
        rd(8'h04, 32'h1);
        pulse_done();
        rd(8'h04, 32'h2);
        rd(8'h10, 32'h4);
        wr(8'h04, 32'h2);
        pulse_done();
        @(negedge clk);
        chk("idle_pulse_ign", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rd(8'h10, 32'h4);
        rd(8'h04, 32'h0);

        // AW ahead of W, stalled response channels
        axi_write(8'h08, 32'h5, 4'hF, 2'b00, 3, 2, 1'b0);
        axi_read(8'h08, 32'h5, 2'b00, 3);
        axi_read(8'h14, 32'hACC0_0001, 2'b00, $urandom_range(1, 4));
        axi_write(8'h0C, 32'h1, 4'hF, 2'b00, 0, $urandom_range(1, 4), 1'b0);

        // byte strobes
        axi_write(8'h08, 32'h1234, 4'b0010, 2'b00, 0, 0, 1'b0);
        @(negedge clk);
        chk("cfg_k_strb", {16'd0, cfg_k}, 32'h1205);
        @(posedge clk); #1;
        rd(8'h08, 32'h1205);
        axi_write(8'h0C, 32'h0, 4'b0000, 2'b00, 0, 0, 1'b0);
        rd(8'h0C, 32'h1);

        // unmapped
        axi_read(8'h1C, 32'h0, 2'b10, 0);
        axi_read(8'h18, 32'h0, 2'b10, 2);
        axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, 1'b0);
        rd(8'h00, 32'h0);

        // strobe-gated START, then reset mid-job
        wr(8'h08, 32'h7);
        s0 = start_cnt;
        axi_write(8'h00, 32'h1, 4'b0000, 2'b00, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("start_strb0", start_cnt - s0, 0);
        @(posedge clk); #1;
        launch("start_pre_rst", 1);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cfg", {16'd0, cfg_k}, 32'd4);
        chk("rst_mid_outs", {29'd0, start, done, irq}, 32'd0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        rd(8'h04, 32'h0);
        rd(8'h10, 32'h0);
        rd(8'h0C, 32'h0);

        repeat (5) @(negedge clk);
        chk("rq_drained", rq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accel_ctrl_regs.md
Name: accel_ctrl_regs

Overview:
- AXI4-Lite slave register block that configures and sequences compute_wrapper.
- Drives cfg_k and a single-cycle start pulse into the wrapper, and tracks BUSY.
- Turns the wrapper's done_pulse into a sticky, software-clearable (W1C) DONE bit, a completion counter and a level interrupt.
- Sits between the host AXI-Lite interconnect and compute_wrapper.

Parameters:
- ADDR_W, 8, AXI-Lite address width (byte address; only bits [4:2] decoded).
- DATA_W, 32, AXI-Lite data width (fixed at 32).
- K_MAX, 64, largest legal cfg_k value.
- K_RESET, 4, reset value of CFG_K.
- ID_VALUE, 32'hACC0_0001, constant returned by the ID register.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  write byte strobes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- cfg_k  out  16  K value presented to compute_wrapper.
- start  out  1  one-cycle job launch pulse.
- done_pulse  in  1  one-cycle completion pulse from the wrapper.
- done  out  1  sticky DONE status.
- irq  out  1  level interrupt.

Behaviour:
- Register map:
  - 0x00 CTRL: bit0 START, write-1 launches a job, always reads 0.
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C).
  - 0x08 CFG_K: [15:0] RW, reset K_RESET.
  - 0x0C IRQ_EN: bit0 RW, reset 0.
  - 0x10 JOB_CNT: 32-bit RO count of completed jobs, wraps 0xFFFFFFFF->0.
  - 0x14 ID: RO, returns ID_VALUE.
  - Unmapped offsets: reads return 0 with SLVERR (2'b10); writes are dropped with SLVERR.
- Reset values: all ready/valid outputs 0, resp 0, rdata 0, start 0, done 0, irq 0, BUSY 0, ERR 0, JOB_CNT 0, cfg_k K_RESET.
- Write channel, FSM W_IDLE -> W_RESP:
  - awready and wready are high in W_IDLE while that channel is not yet latched; AW and W latch independently.
  - The write commits on the edge where both are held, and bvalid rises that same edge.
  - bvalid holds until bready; the FSM then returns to W_IDLE.
  - Byte strobes apply only to CFG_K and IRQ_EN; W1C/START bits act only if their byte lane strobe is set.
- Read channel, FSM R_IDLE -> R_DATA:
  - arready is high in R_IDLE.
  - rdata/rresp are registered; rvalid rises the cycle after the AR handshake and holds stable until rready.
- Job FSM, IDLE -> RUN:
  - Accepted START (IDLE, 1 <= CFG_K <= K_MAX): start=1 for exactly one cycle, the cycle after the commit edge. BUSY, DONE and ERR change on the same edge that raises start: BUSY=1, DONE cleared, ERR unchanged.
  - RUN + done_pulse: next edge BUSY=0, DONE=1, JOB_CNT+1, return to IDLE.
  - START while BUSY, or with CFG_K=0, or with CFG_K>K_MAX: no start pulse, ERR=1.
- cfg_k:
  - Writes to CFG_K while BUSY are ignored (OKAY response); cfg_k is stable for the whole job.
- Simultaneous events:
  - done_pulse in the same cycle as a DONE W1C: set wins, DONE=1.
  - done_pulse while IDLE: ignored; no DONE, no count.
  - A START commit in the same cycle as done_pulse sees BUSY=1 and is rejected with ERR.
- Outputs: done = DONE bit; irq = DONE & IRQ_EN (combinational from registers, no added latency).
- rst mid-job: all state returns to reset values; any in-flight AXI transaction is abandoned.

Decomposition:
- accel_ctrl_pkg holds:
  - register offset localparams and STATUS bit indices;
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10;
  - enums w_state_t, r_state_t, job_state_t.
- One sub-module, axil_reg_if: AXI-Lite handshake FSMs exposing wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr, taking back rd_data/rd_err/wr_err.
- Register decode and the job FSM live in accel_ctrl_regs.

Test Plan:
- Reset, then read 0x08, 0x14, 0x04 -> 0x4, 32'hACC0_0001, 0x0; all OKAY.
- Write CFG_K=4, write CTRL=1 -> start high exactly 1 cycle, BUSY=1. Inject done_pulse after 20 cycles -> done=1, STATUS=0x2, JOB_CNT=1. done stays 1 for 10+ cycles.
- Set IRQ_EN=1, run a job -> irq rises with done. Write STATUS=0x2 -> done=0 and irq=0 the cycle after commit.
- START while BUSY, and START with CFG_K=0 or CFG_K=65 -> no start pulse, STATUS bit2=1; W1C 0x4 clears it.
- Writing CFG_K=8 while BUSY -> reads back 4. Done_pulse coincident with a DONE W1C -> DONE=1.
- AW presented 3 cycles before W, and bready/rready randomly stalled -> bvalid/rvalid and rdata held stable. Access to 0x1C -> SLVERR.
